// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: RV32I funct3 codes, FSM state
// encodings and the registered request record.
package load_store_unit_pkg;

    localparam int DATA_W = 32;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MEM  = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    typedef struct packed {
        logic              store;
        logic [2:0]        funct3;
        logic [DATA_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [4:0]        rd;
    } lsu_req_t;

    // Unsigned loads exist only for byte and halfword; stores have no unsigned forms.
    function automatic logic funct3_legal(input logic is_store, input logic [2:0] funct3);
        if (is_store)
            return (funct3 == F3_SB) || (funct3 == F3_SH) || (funct3 == F3_SW);
        return (funct3 == F3_LB) || (funct3 == F3_LH) || (funct3 == F3_LW) ||
               (funct3 == F3_LBU) || (funct3 == F3_LHU);
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for the load/store unit: store strobes and replication,
// load lane extraction with sign/zero extension, and alignment checking.
module lsu_align
    import load_store_unit_pkg::*;
(
    input  logic [2:0]        funct3,
    input  logic [1:0]        addr_lo,
    input  logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] rdata,
    output logic [3:0]        wstrb,
    output logic [DATA_W-1:0] wdata_lane,
    output logic [DATA_W-1:0] rdata_ext,
    output logic              misaligned
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (addr_lo)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    end

    // funct3[1:0] is the access size, funct3[2] marks an unsigned load.
    always_comb begin
        wstrb      = 4'b1111;
        wdata_lane = wdata;
        rdata_ext  = rdata;
        misaligned = 1'b0;
        case (funct3[1:0])
            2'b00: begin
                wstrb      = 4'b0001 << addr_lo;
                wdata_lane = {4{wdata[7:0]}};
                rdata_ext  = funct3[2] ? {24'b0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
            end
            2'b01: begin
                wstrb      = 4'b0011 << addr_lo;
                wdata_lane = {2{wdata[15:0]}};
                rdata_ext  = funct3[2] ? {16'b0, half_sel} : {{16{half_sel[15]}}, half_sel};
                misaligned = addr_lo[0];
            end
            default: begin
                misaligned = (addr_lo != 2'b00);
            end
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Execute-stage load/store unit: accepts one RV32I access at a time, runs it over
// a single-word memory handshake and returns extended load data or a fault.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_store,
    input  logic [2:0]      req_funct3,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    input  logic [4:0]      req_rd,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    output logic [3:0]      mem_wstrb,
    input  logic            mem_ack,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            resp_valid,
    output logic            resp_we,
    output logic [4:0]      resp_rd,
    output logic [XLEN-1:0] resp_data,
    output logic            resp_fault
);

    logic [1:0]        state;
    lsu_req_t          req_q;
    logic [XLEN-1:0]   data_q;
    logic              fault_q;

    logic              in_idle;
    logic              req_fault;
    logic [2:0]        align_funct3;
    logic [1:0]        align_addr_lo;
    logic [3:0]        lane_wstrb;
    logic [XLEN-1:0]   lane_wdata;
    logic [XLEN-1:0]   lane_rdata;
    logic              lane_misaligned;

    assign in_idle = (state == ST_IDLE);

    // While idle the aligner vets the incoming request; afterwards it works on the held one.
    assign align_funct3  = in_idle ? req_funct3    : req_q.funct3;
    assign align_addr_lo = in_idle ? req_addr[1:0] : req_q.addr[1:0];

    lsu_align u_align (
        .funct3     (align_funct3),
        .addr_lo    (align_addr_lo),
        .wdata      (req_q.wdata),
        .rdata      (mem_rdata),
        .wstrb      (lane_wstrb),
        .wdata_lane (lane_wdata),
        .rdata_ext  (lane_rdata),
        .misaligned (lane_misaligned)
    );

    assign req_fault = lane_misaligned || !funct3_legal(req_store, req_funct3);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state   <= ST_IDLE;
            req_q   <= '0;
            data_q  <= '0;
            fault_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        req_q   <= '{store: req_store, funct3: req_funct3, addr: req_addr,
                                     wdata: req_wdata, rd: req_rd};
                        data_q  <= '0;
                        fault_q <= req_fault;
                        state   <= req_fault ? ST_RESP : ST_MEM;
                    end
                end
                ST_MEM: begin
                    if (mem_ack) begin
                        data_q <= req_q.store ? '0 : lane_rdata;
                        state  <= ST_RESP;
                    end
                end
                ST_RESP: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Every output is qualified by state so a reset clears them all on the next cycle.
    always_comb begin
        req_ready  = in_idle;
        mem_req    = (state == ST_MEM);
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        mem_wstrb  = 4'b0000;
        resp_valid = (state == ST_RESP);
        resp_we    = 1'b0;
        resp_rd    = 5'd0;
        resp_data  = '0;
        resp_fault = 1'b0;
        if (mem_req) begin
            mem_addr = {req_q.addr[XLEN-1:2], 2'b00};
            if (req_q.store) begin
                mem_we    = 1'b1;
                mem_wdata = lane_wdata;
                mem_wstrb = lane_wstrb;
            end
        end
        if (resp_valid) begin
            resp_we    = !req_q.store && !fault_q;
            resp_rd    = req_q.rd;
            resp_data  = data_q;
            resp_fault = fault_q;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: vector table plus hand-written
// back-to-back and mid-access reset sequences, responses checked via a scoreboard.
module tb_load_store_unit;
    import load_store_unit_pkg::*;

    logic        clk;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [4:0]  req_rd;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        resp_valid;
    logic        resp_we;
    logic [4:0]  resp_rd;
    logic [31:0] resp_data;
    logic        resp_fault;

    load_store_unit #(.XLEN(32)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_store  (req_store),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_rd     (req_rd),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wstrb  (mem_wstrb),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .resp_valid (resp_valid),
        .resp_we    (resp_we),
        .resp_rd    (resp_rd),
        .resp_data  (resp_data),
        .resp_fault (resp_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        store;
        logic [2:0]  funct3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [4:0]  rd;
        logic [31:0] rdata;
        int          waits;
        logic [31:0] exp_data;
        logic        exp_we;
        logic        exp_fault;
        logic [3:0]  exp_wstrb;
        logic [31:0] exp_mwdata;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic        we;
        logic [4:0]  rd;
        logic        fault;
    } exp_t;

    exp_t sb[$];
    int   num_checks = 0;
    int   num_pass = 0;
    logic prev_valid = 1'b0;
    vec_t vecs[13];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        num_checks++;
        if (actual === expected)
            num_pass++;
        else
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic waitReady();
        for (int i = 0; i < 20 && !req_ready; i++)
            nextCycle();
        if (!req_ready)
            checkOutput("ready_timeout", 32'(req_ready), 1);
    endtask

    // Responses are popped from the scoreboard as they appear on the response port.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (resp_valid) begin
            checkOutput("resp_single_cycle", 32'(prev_valid), 0);
            if (sb.size() == 0) begin
                checkOutput("resp_unexpected", 32'(resp_valid), 0);
            end else begin
                e = sb.pop_front();
                checkOutput("resp_data", resp_data, e.data);
                checkOutput("resp_we", 32'(resp_we), 32'(e.we));
                checkOutput("resp_rd", 32'(resp_rd), 32'(e.rd));
                checkOutput("resp_fault", 32'(resp_fault), 32'(e.fault));
            end
        end
        prev_valid = resp_valid;
    end

    task automatic applyStimulus(input vec_t v);
        waitReady();
        req_valid  = 1'b1;
        req_store  = v.store;
        req_funct3 = v.funct3;
        req_addr   = v.addr;
        req_wdata  = v.wdata;
        req_rd     = v.rd;
        sb.push_back('{v.exp_data, v.exp_we, v.rd, v.exp_fault});
        nextCycle();
        req_valid = 1'b0;
        if (v.exp_fault) begin
            checkOutput("fault_no_mem_req", 32'(mem_req), 0);
            checkOutput("fault_resp_n1", 32'(resp_valid), 1);
        end else begin
            for (int k = 0; k <= v.waits; k++) begin
                checkOutput("mem_req_held", 32'(mem_req), 1);
                checkOutput("mem_addr", mem_addr, {v.addr[31:2], 2'b00});
                checkOutput("mem_we", 32'(mem_we), 32'(v.store));
                if (v.store) begin
                    checkOutput("mem_wstrb", 32'(mem_wstrb), 32'(v.exp_wstrb));
                    checkOutput("mem_wdata", mem_wdata, v.exp_mwdata);
                end
                checkOutput("resp_quiet", 32'(resp_valid), 0);
                mem_ack   = (k == v.waits);
                mem_rdata = (k == v.waits) ? v.rdata : ~v.rdata;
                nextCycle();
            end
            mem_ack   = 1'b0;
            mem_rdata = 32'h0;
            checkOutput("resp_after_ack", 32'(resp_valid), 1);
            checkOutput("mem_req_drop", 32'(mem_req), 0);
        end
        nextCycle();
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset_n    = 1'b0;
        req_valid  = 1'b1;
        req_store  = 1'b0;
        req_funct3 = F3_LW;
        req_addr   = 32'h100;
        req_wdata  = 32'h0;
        req_rd     = 5'd1;
        mem_ack    = 1'b0;
        mem_rdata  = 32'h0;
        repeat (3) nextCycle();

        // Reset must win over a pending request.
        checkOutput("rst_req_ready", 32'(req_ready), 1);
        checkOutput("rst_mem_req", 32'(mem_req), 0);
        checkOutput("rst_mem_we", 32'(mem_we), 0);
        checkOutput("rst_mem_addr", mem_addr, 0);
        checkOutput("rst_mem_wstrb", 32'(mem_wstrb), 0);
        checkOutput("rst_resp_valid", 32'(resp_valid), 0);
        checkOutput("rst_resp_data", resp_data, 0);
        req_valid = 1'b0;
        reset_n   = 1'b1;
        nextCycle();

        vecs[0]  = '{1'b0, F3_LW,  32'h100, 32'h0,      5'd5,  32'hDEADBEEF, 2, 32'hDEADBEEF, 1'b1, 1'b0, 4'h0, 32'h0};
        vecs[1]  = '{1'b0, F3_LB,  32'h103, 32'h0,      5'd6,  32'h80123456, 0, 32'hFFFFFF80, 1'b1, 1'b0, 4'h0, 32'h0};
        vecs[2]  = '{1'b0, F3_LBU, 32'h103, 32'h0,      5'd7,  32'h80123456, 1, 32'h00000080, 1'b1, 1'b0, 4'h0, 32'h0};
        vecs[3]  = '{1'b0, F3_LH,  32'h102, 32'h0,      5'd8,  32'h80017FFF, 1, 32'hFFFF8001, 1'b1, 1'b0, 4'h0, 32'h0};
        vecs[4]  = '{1'b0, F3_LHU, 32'h100, 32'h0,      5'd9,  32'h8001F00F, 0, 32'h0000F00F, 1'b1, 1'b0, 4'h0, 32'h0};
        vecs[5]  = '{1'b0, F3_LB,  32'h101, 32'h0,      5'd11, 32'h12347F56, 3, 32'h0000007F, 1'b1, 1'b0, 4'h0, 32'h0};
        vecs[6]  = '{1'b1, F3_SH,  32'h102, 32'h1234ABCD, 5'd12, 32'h0,      1, 32'h0,        1'b0, 1'b0, 4'hC, 32'hABCDABCD};
        vecs[7]  = '{1'b1, F3_SB,  32'h201, 32'h000000A5, 5'd13, 32'h0,      0, 32'h0,        1'b0, 1'b0, 4'h2, 32'hA5A5A5A5};
        vecs[8]  = '{1'b1, F3_SW,  32'h204, 32'hCAFEF00D, 5'd14, 32'h0,      2, 32'h0,        1'b0, 1'b0, 4'hF, 32'hCAFEF00D};
        vecs[9]  = '{1'b0, F3_LW,  32'h101, 32'h0,      5'd15, 32'h0,        0, 32'h0,        1'b0, 1'b1, 4'h0, 32'h0};
        vecs[10] = '{1'b1, F3_SH,  32'h001, 32'h5555,   5'd16, 32'h0,        0, 32'h0,        1'b0, 1'b1, 4'h0, 32'h0};
        vecs[11] = '{1'b0, 3'b011, 32'h100, 32'h0,      5'd17, 32'h0,        0, 32'h0,        1'b0, 1'b1, 4'h0, 32'h0};
        vecs[12] = '{1'b1, 3'b100, 32'h100, 32'h0,      5'd18, 32'h0,        0, 32'h0,        1'b0, 1'b1, 4'h0, 32'h0};

        for (int i = 0; i < 13; i++)
            applyStimulus(vecs[i]);

        // Zero-wait SB then LW with req_valid held: accepts land three cycles apart.
        waitReady();
        req_valid  = 1'b1;
        req_store  = 1'b1;
        req_funct3 = F3_SB;
        req_addr   = 32'h303;
        req_wdata  = 32'h00000011;
        req_rd     = 5'd19;
        sb.push_back('{32'h0, 1'b0, 5'd19, 1'b0});
        nextCycle();
        req_store  = 1'b0;
        req_funct3 = F3_LW;
        req_addr   = 32'h304;
        req_rd     = 5'd20;
        sb.push_back('{32'h55AA00FF, 1'b1, 5'd20, 1'b0});
        checkOutput("b2b_ready_n1", 32'(req_ready), 0);
        checkOutput("b2b_mem_req_n1", 32'(mem_req), 1);
        checkOutput("b2b_mem_addr_sb", mem_addr, 32'h300);
        checkOutput("b2b_wstrb_sb", 32'(mem_wstrb), 32'h8);
        checkOutput("b2b_wdata_sb", mem_wdata, 32'h11111111);
        mem_ack   = 1'b1;
        mem_rdata = 32'hFFFFFFFF;
        nextCycle();
        mem_ack = 1'b0;
        checkOutput("b2b_ready_n2", 32'(req_ready), 0);
        checkOutput("b2b_resp_n2", 32'(resp_valid), 1);
        checkOutput("b2b_mem_req_n2", 32'(mem_req), 0);
        nextCycle();
        checkOutput("b2b_ready_n3", 32'(req_ready), 1);
        nextCycle();
        req_valid = 1'b0;
        checkOutput("b2b_mem_req_n4", 32'(mem_req), 1);
        checkOutput("b2b_mem_addr_lw", mem_addr, 32'h304);
        checkOutput("b2b_mem_we_lw", 32'(mem_we), 0);
        checkOutput("b2b_ready_n4", 32'(req_ready), 0);
        mem_ack   = 1'b1;
        mem_rdata = 32'h55AA00FF;
        nextCycle();
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
        checkOutput("b2b_resp_lw", 32'(resp_valid), 1);
        nextCycle();

        // Reset while waiting on memory abandons the access; a late ack is ignored.
        waitReady();
        req_valid  = 1'b1;
        req_store  = 1'b0;
        req_funct3 = F3_LW;
        req_addr   = 32'h400;
        req_rd     = 5'd21;
        nextCycle();
        req_valid = 1'b0;
        checkOutput("rmem_mem_req", 32'(mem_req), 1);
        nextCycle();
        checkOutput("rmem_mem_req_wait", 32'(mem_req), 1);
        reset_n = 1'b0;
        nextCycle();
        reset_n = 1'b1;
        checkOutput("rmem_ready", 32'(req_ready), 1);
        checkOutput("rmem_mem_req_off", 32'(mem_req), 0);
        checkOutput("rmem_mem_addr", mem_addr, 0);
        checkOutput("rmem_resp_valid", 32'(resp_valid), 0);
        mem_ack   = 1'b1;
        mem_rdata = 32'h12345678;
        nextCycle();
        mem_ack = 1'b0;
        checkOutput("late_ack_ready", 32'(req_ready), 1);
        checkOutput("late_ack_mem_req", 32'(mem_req), 0);
        checkOutput("late_ack_resp", 32'(resp_valid), 0);
        repeat (3) nextCycle();

        checkOutput("scoreboard_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", num_pass, num_checks);
        $finish;
    end

endmodule
